bcd_ascii_serializer: RTL and testbench



---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_ascii.sv | 13 +
 rtl/bcd_ascii_serializer.sv | 131 +++++++++++++
 tb/tb_bcd_ascii_serializer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD-to-ASCII serializer slice.
//   state_t     : serializer FSM states (IDLE=0 .. TERM=4)
//   ASCII_*     : character constants used for digit encoding and the
//                 default line terminator.
package bcd_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HUND = 3'd1,
    TENS = 3'd2,
    ONES = 3'd3,
    TERM = 3'd4
  } state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

endpackage

// File: rtl/bcd_digit_ascii.sv
// Combinational BCD digit to ASCII encoder.
//   digit : 4-bit BCD digit
//   ascii : '0'..'9' for 0..9, '?' for any value above 9
module bcd_digit_ascii
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ascii
);

  assign ascii = (digit > 4'd9) ? ASCII_QMARK : (ASCII_ZERO + {4'h0, digit});

endmodule

// File: rtl/bcd_ascii_serializer.sv
// Serializes one BCD triple (hundreds/tens/ones) into a stream of ASCII
// characters, with optional leading-zero suppression and terminator.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   in_valid/ready  : BCD triple handshake (in_ready only in IDLE)
//   in_hundreds     : hundreds digit (0-2, 3 is illegal)
//   in_tens/in_ones : tens / ones digits (0-9, >9 illegal)
//   out_valid/ready : character handshake
//   out_data        : ASCII character
//   out_last        : marks the final character of a number
//   dbg_state       : current FSM state, for observation only
//
// Handshake rule for both ports: a transfer happens on a rising clk edge
// where valid and ready are both high; the producer holds its payload
// stable while valid is high and ready is low, and never withdraws valid
// before the transfer.
module bcd_ascii_serializer
  import bcd_pkg::*;
#(
  parameter bit         SUPPRESS_ZEROS = 1'b1,
  parameter bit         TERM_EN        = 1'b1,
  parameter logic [7:0] TERM_CHAR      = ASCII_LF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_hundreds,
  input  logic [3:0] in_tens,
  input  logic [3:0] in_ones,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [2:0] dbg_state
);

  state_t     state, state_next;
  logic [1:0] hund_q;
  logic [3:0] tens_q, ones_q;

  logic       accept, xfer, load;
  logic [1:0] cur_h;
  logic [3:0] cur_t, cur_o;
  logic [3:0] mux_digit;
  logic [7:0] digit_ascii;
  logic [7:0] data_next;
  logic       last_next;

  // out_valid is a pure decode of the state register, so it drops as soon
  // as the asynchronous reset forces IDLE.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state != IDLE);
  assign dbg_state = state;

  assign accept = in_valid & in_ready;
  assign xfer   = out_valid & out_ready;

  always_comb begin
    state_next = state;
    // On accept the character for the first state must come straight from
    // the inputs, because the digit registers are loaded on the same edge.
    cur_h = hund_q;
    cur_t = tens_q;
    cur_o = ones_q;
    if (accept) begin
      cur_h = in_hundreds;
      cur_t = in_tens;
      cur_o = in_ones;
    end

    case (state)
      IDLE: begin
        if (in_valid) begin
          // Illegal digits are non-zero, so they are never suppressed.
          if ((in_hundreds != 2'd0) || !SUPPRESS_ZEROS) state_next = HUND;
          else if (in_tens != 4'd0)                    state_next = TENS;
          else                                         state_next = ONES;
        end
      end
      HUND:    if (xfer) state_next = TENS;
      TENS:    if (xfer) state_next = ONES;
      ONES:    if (xfer) state_next = TERM_EN ? TERM : IDLE;
      TERM:    if (xfer) state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Single encoder shared by all digit positions; hundreds=3 is mapped
    // onto an out-of-range code so it encodes as '?'.
    case (state_next)
      HUND:    mux_digit = (cur_h == 2'd3) ? 4'hF : {2'b00, cur_h};
      TENS:    mux_digit = cur_t;
      default: mux_digit = cur_o;
    endcase

    data_next = (state_next == TERM) ? TERM_CHAR : digit_ascii;
    last_next = (state_next == TERM) || ((state_next == ONES) && !TERM_EN);

    // Output registers only move when a new character becomes current.
    load = accept | (xfer & (state_next != IDLE));
  end

  bcd_digit_ascii u_enc (
    .digit (mux_digit),
    .ascii (digit_ascii)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hund_q   <= 2'd0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      out_data <= 8'h00;
      out_last <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        hund_q <= in_hundreds;
        tens_q <= in_tens;
        ones_q <= in_ones;
      end
      if (load) begin
        out_data <= data_next;
        out_last <= last_next;
      end
    end
  end

endmodule

// File: tb/tb_bcd_ascii_serializer.sv
// Bench for bcd_ascii_serializer. Three instances run side by side:
//   u0 : zero suppression on,  terminator on  (defaults)
//   u1 : zero suppression off, terminator on
//   u2 : zero suppression on,  terminator off
module tb_bcd_ascii_serializer;

  logic       clk;
  logic       rst;
  logic [2:0] in_valid;
  logic [1:0] in_hundreds;
  logic [3:0] in_tens, in_ones;
  logic [2:0] out_ready;
  wire  [2:0] in_ready, out_valid, out_last;
  wire  [7:0] out_data [3];
  wire  [2:0] dbg_state [3];

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;   // 0: ready high, 1: random ready, 2: driven by test
  int xfer_cnt [3];

  logic [8:0] exp_q0[$];
  logic [8:0] exp_q1[$];
  logic [8:0] exp_q2[$];

  logic       stall_prev [3];
  logic [8:0] held [3];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  bcd_ascii_serializer u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_hundreds(in_hundreds), .in_tens(in_tens), .in_ones(in_ones),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .dbg_state(dbg_state[0])
  );

  bcd_ascii_serializer #(.SUPPRESS_ZEROS(1'b0), .TERM_EN(1'b1), .TERM_CHAR(8'h0A)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_hundreds(in_hundreds), .in_tens(in_tens), .in_ones(in_ones),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .dbg_state(dbg_state[1])
  );

  bcd_ascii_serializer #(.SUPPRESS_ZEROS(1'b1), .TERM_EN(1'b0), .TERM_CHAR(8'h0A)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_hundreds(in_hundreds), .in_tens(in_tens), .in_ones(in_ones),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
    .out_last(out_last[2]), .dbg_state(dbg_state[2])
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] enc(input int v, input int maxv);
    return (v <= maxv) ? 8'(8'h30 + v) : 8'h3F;
  endfunction

  task automatic push_exp(input int inst, input logic [8:0] v);
    case (inst)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  // Character list of a number: skip leading zeros only before the first
  // emitted digit, ones always sent, terminator optional.
  task automatic expect_number(input int inst, input int h, input int t, input int o);
    int  d [3];
    int  maxv [3];
    bit  sup, term, started;
    d = '{h, t, o};
    maxv = '{2, 9, 9};
    sup  = (inst != 1);
    term = (inst != 2);
    started = !sup;
    for (int i = 0; i < 3; i++) begin
      if (i == 2 || d[i] != 0) started = 1'b1;
      if (started) push_exp(inst, {(i == 2) && !term, enc(d[i], maxv[i])});
    end
    if (term) push_exp(inst, {1'b1, 8'h0A});
  endtask

  task automatic pop_check(input int inst);
    logic [8:0] e;
    int sz;
    case (inst)
      0:       sz = exp_q0.size();
      1:       sz = exp_q1.size();
      default: sz = exp_q2.size();
    endcase
    if (sz == 0) begin
      chk($sformatf("u%0d_unexpected_char", inst), {23'd0, out_last[inst], out_data[inst]}, 32'h1FF00);
    end else begin
      case (inst)
        0:       e = exp_q0.pop_front();
        1:       e = exp_q1.pop_front();
        default: e = exp_q2.pop_front();
      endcase
      chk($sformatf("u%0d_data", inst), out_data[inst], e[7:0]);
      chk($sformatf("u%0d_last", inst), out_last[inst], e[8]);
    end
  endtask

  // Monitor: every transfer is scored; a stalled character must hold.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) stall_prev[i] = 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stall_prev[i]) begin
          chk($sformatf("u%0d_hold_valid", i), out_valid[i], 1);
          chk($sformatf("u%0d_hold_data", i), {out_last[i], out_data[i]}, held[i]);
        end
        if (out_valid[i] && out_ready[i]) begin
          xfer_cnt[i]++;
          pop_check(i);
        end
        stall_prev[i] = out_valid[i] && !out_ready[i];
        held[i] = {out_last[i], out_data[i]};
      end
    end
  end

  // Sink ready driver, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 3'b111;
    else if (rdy_mode == 1) out_ready = 3'($urandom_range(0, 7));
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input logic [2:0] mask);
    int n = 0;
    @(negedge clk);
    while (((in_ready & mask) != mask) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("idle_timeout", 0, 1);
  endtask

  // Presents a triple to the instances in mask; returns 1 time unit after
  // the rising edge on which the last of them accepted it.
  task automatic send(input int h, input int t, input int o, input logic [2:0] mask);
    logic [2:0] acc;
    int n = 0;
    wait_idle(mask);
    @(posedge clk); #1;
    in_hundreds = 2'(h);
    in_tens     = 4'(t);
    in_ones     = 4'(o);
    for (int i = 0; i < 3; i++) if (mask[i]) expect_number(i, h, t, o);
    in_valid = mask;
    while (in_valid != 3'b000 && n < 50) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk); #1;
      in_valid = in_valid & ~acc;
      n++;
    end
    if (n >= 50) begin
      chk("accept_timeout", 0, 1);
      in_valid = 3'b000;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pat [7];
    int base;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    rst = 1'b1;
    in_valid = 3'b000;
    in_hundreds = 2'd0;
    in_tens = 4'd0;
    in_ones = 4'd0;
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) xfer_cnt[i] = 0;

    #12;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d_rst_valid", i), out_valid[i], 0);
      chk($sformatf("u%0d_rst_data", i), out_data[i], 8'h00);
      chk($sformatf("u%0d_rst_last", i), out_last[i], 0);
      chk($sformatf("u%0d_rst_ready", i), in_ready[i], 1);
      chk($sformatf("u%0d_rst_state", i), dbg_state[i], 0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // 2/5/5 with ready high: four characters on consecutive cycles,
    // starting one cycle after accept, then idle again.
    send(2, 5, 5, 3'b001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("lat_valid", out_valid[0], 1);
      chk("lat_in_ready", in_ready[0], 0);
    end
    @(negedge clk);
    chk("end_valid", out_valid[0], 0);
    chk("end_in_ready", in_ready[0], 1);

    // Directed numbers on all three configurations.
    send(0, 0, 7, 3'b111);
    send(0, 0, 0, 3'b111);
    send(1, 0, 5, 3'b111);
    send(0, 12, 3, 3'b111);
    send(0, 4, 2, 3'b111);
    send(3, 10, 15, 3'b111);
    wait_idle(3'b111);

    // Stall pattern on u0.
    rdy_mode = 2;
    out_ready = 3'b000;
    base = xfer_cnt[0];
    send(2, 5, 5, 3'b001);
    for (int k = 0; k < 7; k++) begin
      out_ready[0] = pat[k][0];
      @(posedge clk); #1;
    end
    chk("stall_xfers", xfer_cnt[0] - base, 4);
    chk("stall_done_valid", out_valid[0], 0);
    rdy_mode = 0;
    out_ready = 3'b111;

    // Asynchronous reset after the second character of 1/2/3.
    send(1, 2, 3, 3'b001);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid[0], 0);
    chk("arst_in_ready", in_ready[0], 1);
    chk("arst_state", dbg_state[0], 0);
    chk("arst_xfers_before", exp_q0.size(), 2);
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    send(0, 0, 9, 3'b001);
    wait_idle(3'b001);

    // Back-to-back with in_valid held high on u0.
    @(posedge clk); #1;
    in_hundreds = 2'd0; in_tens = 4'd0; in_ones = 4'd1;
    expect_number(0, 0, 0, 1);
    in_valid = 3'b001;
    @(posedge clk); #1;
    in_ones = 4'd2;
    expect_number(0, 0, 0, 2);
    @(negedge clk);
    chk("b2b_rdy0", in_ready[0], 0);
    chk("b2b_val0", out_valid[0], 1);
    @(negedge clk);
    chk("b2b_rdy1", in_ready[0], 0);
    chk("b2b_val1", out_valid[0], 1);
    @(negedge clk);
    chk("b2b_rdy2", in_ready[0], 1);
    chk("b2b_val2", out_valid[0], 0);
    @(negedge clk);
    chk("b2b_rdy3", in_ready[0], 0);
    chk("b2b_val3", out_valid[0], 1);
    @(posedge clk); #1;
    in_valid = 3'b000;
    wait_idle(3'b111);

    // Randomized numbers with random sink back-pressure.
    rdy_mode = 1;
    for (int n = 0; n < 60; n++) begin
      int h, t, o;
      h = $urandom_range(0, 3);
      t = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      o = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      if ($urandom_range(0, 2) == 0) begin h = 0; t = 0; end
      send(h, t, o, 3'b111);
    end
    wait_idle(3'b111);
    rdy_mode = 0;

    chk("u0_queue_empty", exp_q0.size(), 0);
    chk("u1_queue_empty", exp_q1.size(), 0);
    chk("u2_queue_empty", exp_q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #400000;
    chk("global_timeout", 0, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit reached");
  end

endmodule
